// File: rtl/pipe_stage_hs_reg_pkg.sv
// Shared definitions for the handshaked inter-stage pipeline register:
// state encoding and the default ID/EX payload packing used to build bubble masks.
package pipe_stage_hs_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Default ID/EX packing of the 256-bit stage payload, LSB first.
    localparam int IDEX_W         = 256;
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_PC_W      = 32;
    localparam int IDEX_INSTR_LSB = 32;
    localparam int IDEX_INSTR_W   = 32;
    localparam int IDEX_IMM_LSB   = 64;
    localparam int IDEX_IMM_W     = 32;
    localparam int IDEX_RS1_LSB   = 96;
    localparam int IDEX_RS1_W     = 5;
    localparam int IDEX_RS2_LSB   = 101;
    localparam int IDEX_RS2_W     = 5;
    localparam int IDEX_RD_LSB    = 106;
    localparam int IDEX_RD_W      = 5;
    localparam int IDEX_WBEN_LSB  = 111;
    localparam int IDEX_WBEN_W    = 1;
    localparam int IDEX_CTRL_LSB  = 112;
    localparam int IDEX_CTRL_W    = 144;

    function automatic logic [IDEX_W-1:0] field_mask(input int lsb, input int width);
        logic [IDEX_W-1:0] m;
        m = {IDEX_W{1'b0}};
        for (int i = 0; i < IDEX_W; i++) begin
            if ((i >= lsb) && (i < lsb + width)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // A bubble only needs pc, instr and wben zeroed to decode as a harmless NOP.
    localparam logic [IDEX_W-1:0] IDEX_BUBBLE_MASK =
        field_mask(IDEX_PC_LSB,    IDEX_PC_W)    |
        field_mask(IDEX_INSTR_LSB, IDEX_INSTR_W) |
        field_mask(IDEX_WBEN_LSB,  IDEX_WBEN_W);

endpackage

// File: rtl/pipe_stage_hs_reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_stage_hs_reg_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// flush, bubble masking and a saturating backpressure counter.
module pipe_stage_hs_reg
    import pipe_stage_hs_reg_pkg::*;
#(
    parameter int                   PAYLOAD_W   = 256,
    parameter int                   SKID        = 1,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_MASK = {PAYLOAD_W{1'b1}},
    parameter int                   STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [PAYLOAD_W-1:0]   in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PAYLOAD_W-1:0]   out_data_o,
    input  logic                   flush_i,
    output logic [1:0]             occ_o,
    input  logic                   cnt_clr_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_e               state_q;
    state_e               state_d;
    state_e               state_nom;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] main_nom;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] skid_d;
    logic [PAYLOAD_W-1:0] skid_nom;
    logic                 in_ready;
    logic                 out_valid;
    logic                 in_fire;
    logic                 out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid_i & in_ready;
    assign out_fire  = out_valid & out_ready_i;

    // handshake FSM: where the next beat lands and which entry drains
    always_comb begin
        state_nom = state_q;
        main_nom  = main_q;
        skid_nom  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nom = ST_BUSY;
                    main_nom  = in_data_i;
                end else begin
                    state_nom = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    state_nom = ST_BUSY;
                    main_nom  = in_data_i;
                end else if (in_fire && (SKID != 0)) begin
                    state_nom = ST_FULL;
                    skid_nom  = in_data_i;
                end else if (out_fire) begin
                    state_nom = ST_EMPTY;
                end else begin
                    state_nom = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nom = ST_BUSY;
                    main_nom  = skid_q;
                end else begin
                    state_nom = ST_FULL;
                end
            end
            default: begin
                state_nom = ST_EMPTY;
            end
        endcase
    end

    // Flush empties the stage and drops any same-cycle beat; data regs keep
    // their contents because the bubble mask hides them.
    assign state_d = flush_i ? ST_EMPTY : state_nom;
    assign main_d  = flush_i ? main_q   : main_nom;
    assign skid_d  = flush_i ? skid_q   : skid_nom;

    // state and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= {PAYLOAD_W{1'b0}};
            skid_q  <= {PAYLOAD_W{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            // registered ready: accept whenever the skid slot will be free
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = out_ready_i | ~out_valid;
        end
    endgenerate

    pipe_stage_hs_reg_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (out_valid & ~out_ready_i),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign out_data_o  = main_q & ~(out_valid ? {PAYLOAD_W{1'b0}} : BUBBLE_MASK);
    assign occ_o       = {state_q == ST_FULL, state_q == ST_BUSY};

endmodule

// File: tb/tb_pipe_stage_hs_reg.sv
// Bench for pipe_stage_hs_reg: one SKID=1 and one SKID=0 instance, directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_pipe_stage_hs_reg;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush, s_cnt_clr;
    logic [7:0] s_in_data, s_out_data;
    logic [1:0] s_occ;
    logic [3:0] s_cnt;

    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_flush, n_cnt_clr;
    logic [7:0] n_in_data, n_out_data;
    logic [1:0] n_occ;
    logic [3:0] n_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_hs_reg #(
        .PAYLOAD_W(8), .SKID(1), .BUBBLE_MASK(8'hFF), .STALL_CNT_W(4)
    ) u_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .flush_i(s_flush), .occ_o(s_occ), .cnt_clr_i(s_cnt_clr), .stall_cnt_o(s_cnt)
    );

    pipe_stage_hs_reg #(
        .PAYLOAD_W(8), .SKID(0), .BUBBLE_MASK(8'hFF), .STALL_CNT_W(4)
    ) u_n (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(n_in_valid), .in_ready_o(n_in_ready), .in_data_i(n_in_data),
        .out_valid_o(n_out_valid), .out_ready_i(n_out_ready), .out_data_o(n_out_data),
        .flush_i(n_flush), .occ_o(n_occ), .cnt_clr_i(n_cnt_clr), .stall_cnt_o(n_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0; s_flush = 1'b0; s_cnt_clr = 1'b0;
        n_in_valid = 1'b0; n_in_data = 8'h00; n_out_ready = 1'b0; n_flush = 1'b0; n_cnt_clr = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %0h exp 0", s_out_valid); end
        checks++; if (s_occ !== 2'd0) begin errors++; $display("FAIL reset_s_occ got %0d exp 0", s_occ); end
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL reset_s_cnt got %0h exp 0", s_cnt); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0h exp 1", s_in_ready); end
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL reset_s_data got %0h exp 00", s_out_data); end
        checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_n_valid got %0h exp 0", n_out_valid); end
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n_ready got %0h exp 1", n_in_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %0h exp 1", s_in_ready); end
    endtask

    task automatic test_basic();
        apply_reset();
        s_in_valid = 1'b1; s_in_data = 8'hA5; s_out_ready = 1'b1;
        #1;
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL basic_pre_data got %0h exp 00", s_out_data); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL basic_pre_ready got %0h exp 1", s_in_ready); end
        tick();
        s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", s_out_valid); end
        checks++; if (s_out_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %0h exp a5", s_out_data); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0h exp 0", s_out_valid); end
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL basic_bubble got %0h exp 00", s_out_data); end
    endtask

    task automatic test_skid_fill();
        apply_reset();
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 8'h11;
        tick();
        s_in_data = 8'h22;
        checks++; if (s_occ !== 2'd1) begin errors++; $display("FAIL fill_occ1 got %0d exp 1", s_occ); end
        tick();
        s_in_data = 8'h33;
        checks++; if (s_occ !== 2'd2) begin errors++; $display("FAIL fill_occ2 got %0d exp 2", s_occ); end
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0h exp 0", s_in_ready); end
        tick();
        checks++; if (s_occ !== 2'd2) begin errors++; $display("FAIL fill_held_occ got %0d exp 2", s_occ); end
        checks++; if (s_out_data !== 8'h11) begin errors++; $display("FAIL fill_stable got %0h exp 11", s_out_data); end
        s_out_ready = 1'b1;
        tick();
        checks++; if (s_out_data !== 8'h22) begin errors++; $display("FAIL drain_2nd got %0h exp 22", s_out_data); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %0h exp 1", s_in_ready); end
        tick();
        s_in_valid = 1'b0;
        checks++; if (s_out_data !== 8'h33) begin errors++; $display("FAIL drain_3rd got %0h exp 33", s_out_data); end
        checks++; if (s_occ !== 2'd1) begin errors++; $display("FAIL drain_occ got %0d exp 1", s_occ); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0h exp 0", s_out_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 8'h11;
        tick();
        s_in_data = 8'h22;
        tick();
        s_in_data = 8'h44; s_flush = 1'b1;
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", s_out_valid); end
        checks++; if (s_occ !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", s_occ); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h exp 1", s_in_ready); end
        s_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_out_valid !== 1'b0 || s_out_data !== 8'h00) begin errors++; $display("FAIL flush_no44 got v=%0h d=%0h exp v=0 d=00", s_out_valid, s_out_data); end
        end
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h55;
        tick();
        s_in_data = 8'h66; s_flush = 1'b1;
        #1;
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_ready got %0h exp 1", s_in_ready); end
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop66 got %0h exp 0", s_out_valid); end
    endtask

    task automatic test_noskid_toggle();
        logic [7:0] rec [4];
        int sent;
        int got;
        int nocc;
        bit in_f;
        bit out_f;
        apply_reset();
        sent = 0; got = 0; nocc = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            n_out_ready = (c % 2 == 0);
            n_in_valid  = (sent < 4);
            n_in_data   = 8'(sent + 1);
            #1;
            checks++; if (n_in_ready !== (n_out_ready | (nocc == 0))) begin errors++; $display("FAIL nsk_ready c%0d got %0h exp %0h", c, n_in_ready, (n_out_ready | (nocc == 0))); end
            if (n_out_valid && n_out_ready) begin
                rec[got] = n_out_data;
                got++;
            end
            in_f  = n_in_valid && (n_out_ready || nocc == 0);
            out_f = (nocc == 1) && n_out_ready;
            nocc  = nocc - int'(out_f) + int'(in_f);
            if (in_f) sent++;
            tick();
        end
        n_in_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL nsk_count got %0d exp 4", got); end
        for (int i = 0; i < got; i++) begin
            checks++; if (rec[i] !== 8'(i + 1)) begin errors++; $display("FAIL nsk_order[%0d] got %0h exp %0h", i, rec[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h77;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (s_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0h exp e", s_cnt); end
        tick();
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_15 got %0h exp f", s_cnt); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %0h exp f", s_cnt); end
        checks++; if (s_out_data !== 8'h77) begin errors++; $display("FAIL sat_stable got %0h exp 77", s_out_data); end
        s_cnt_clr = 1'b1;
        tick();
        s_cnt_clr = 1'b0;
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL sat_clr got %0h exp 0", s_cnt); end
        tick();
        checks++; if (s_cnt !== 4'h1) begin errors++; $display("FAIL sat_resume got %0h exp 1", s_cnt); end
        s_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h11;
        tick();
        s_in_data = 8'h22;
        tick();
        s_in_valid = 1'b0;
        tick();
        checks++; if (s_occ !== 2'd2) begin errors++; $display("FAIL mid_pre_occ got %0d exp 2", s_occ); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h exp 0", s_out_valid); end
        checks++; if (s_occ !== 2'd0) begin errors++; $display("FAIL mid_occ got %0d exp 0", s_occ); end
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL mid_cnt got %0h exp 0", s_cnt); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0h exp 1", s_in_ready); end
        #1;
        rst_n = 1'b1;
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b1;
        tick();
        s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h5A) begin errors++; $display("FAIL mid_after got v=%0h d=%0h exp v=1 d=5a", s_out_valid, s_out_data); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got %0h exp 0", s_out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] sq[$];
        logic [7:0] nq[$];
        logic [3:0] scnt;
        logic [3:0] ncnt;
        logic       s_rdy;
        logic       n_rdy;
        logic       s_v;
        logic       n_v;
        logic [7:0] s_d;
        logic [7:0] n_d;
        apply_reset();
        scnt = 4'h0; ncnt = 4'h0;
        for (int c = 0; c < 600; c++) begin
            s_in_valid = ($urandom_range(0, 3) != 0); s_in_data = 8'($urandom);
            s_out_ready = ($urandom_range(0, 1) != 0); s_flush = ($urandom_range(0, 19) == 0);
            s_cnt_clr = ($urandom_range(0, 15) == 0);
            n_in_valid = ($urandom_range(0, 3) != 0); n_in_data = 8'($urandom);
            n_out_ready = ($urandom_range(0, 1) != 0); n_flush = ($urandom_range(0, 19) == 0);
            n_cnt_clr = ($urandom_range(0, 15) == 0);
            #1;
            s_v = (sq.size() > 0); s_rdy = (sq.size() < 2); s_d = s_v ? sq[0] : 8'h00;
            n_v = (nq.size() > 0); n_rdy = n_out_ready || (nq.size() == 0); n_d = n_v ? nq[0] : 8'h00;
            checks++; if (s_in_ready !== s_rdy) begin errors++; $display("FAIL rnd_s_ready c%0d got %0h exp %0h", c, s_in_ready, s_rdy); end
            checks++; if (s_out_valid !== s_v || s_out_data !== s_d) begin errors++; $display("FAIL rnd_s_out c%0d got v=%0h d=%0h exp v=%0h d=%0h", c, s_out_valid, s_out_data, s_v, s_d); end
            checks++; if (s_occ !== 2'(sq.size()) || s_cnt !== scnt) begin errors++; $display("FAIL rnd_s_occcnt c%0d got occ=%0d cnt=%0h exp occ=%0d cnt=%0h", c, s_occ, s_cnt, sq.size(), scnt); end
            checks++; if (n_in_ready !== n_rdy) begin errors++; $display("FAIL rnd_n_ready c%0d got %0h exp %0h", c, n_in_ready, n_rdy); end
            checks++; if (n_out_valid !== n_v || n_out_data !== n_d) begin errors++; $display("FAIL rnd_n_out c%0d got v=%0h d=%0h exp v=%0h d=%0h", c, n_out_valid, n_out_data, n_v, n_d); end
            checks++; if (n_occ !== 2'(nq.size()) || n_cnt !== ncnt) begin errors++; $display("FAIL rnd_n_occcnt c%0d got occ=%0d cnt=%0h exp occ=%0d cnt=%0h", c, n_occ, n_cnt, nq.size(), ncnt); end
            if (s_cnt_clr) scnt = 4'h0;
            else if (s_v && !s_out_ready && scnt != 4'hF) scnt = scnt + 4'h1;
            if (n_cnt_clr) ncnt = 4'h0;
            else if (n_v && !n_out_ready && ncnt != 4'hF) ncnt = ncnt + 4'h1;
            if (s_flush) sq.delete();
            else begin
                if (s_v && s_out_ready) void'(sq.pop_front());
                if (s_in_valid && s_rdy) sq.push_back(s_in_data);
            end
            if (n_flush) nq.delete();
            else begin
                if (n_v && n_out_ready) void'(nq.pop_front());
                if (n_in_valid && n_rdy) nq.push_back(n_in_data);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_skid_fill();
        test_flush();
        test_noskid_toggle();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
